// File: rtl/scr1_in_stage_pkg.sv
// Shared constants and types for the scr1 input-staging block.
//   - legal parameter ranges
//   - memory channel indices
//   - stall FSM state type
//   - memory response encoding used when a channel is held off
package scr1_in_stage_pkg;

    localparam int unsigned DEPTH_MAX    = 4;
    localparam int unsigned NUM_CH_MAX   = 4;

    localparam int unsigned SCR1_CH_IMEM = 0;
    localparam int unsigned SCR1_CH_DMEM = 1;

    // Width of one packed memory response field (type_scr1_mem_resp_e)
    localparam int unsigned MEM_RESP_W   = 2;

    // Same encoding as SCR1_MEM_RESP_NOTRDY in scr1_memif.svh
    localparam logic [MEM_RESP_W-1:0] SCR1_MEM_RESP_NOTRDY = 2'b00;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } type_scr1_stall_fsm_e;

endpackage : scr1_in_stage_pkg

// File: rtl/scr1_rst_sync_cell.sv
// Reset synchroniser: asynchronous assertion, synchronous deassertion.
// Ports:
//   clk        - core clock
//   rst_n      - block reset, async active-low
//   rst_in_n   - raw reset request, async active-low
//   rst_out_n  - synchronised reset, high on the STAGES-th edge after release
module scr1_rst_sync_cell #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_in_n,
    output logic rst_out_n
);

    logic              arst_n;
    logic [STAGES-1:0] sync_q;

    // Either the block reset or the request itself clears the chain
    assign arst_n = rst_n & rst_in_n;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_out_n = sync_q[STAGES-1];

endmodule : scr1_rst_sync_cell

// File: rtl/scr1_in_stage.sv
// Input-staging block between the fuzz harness and scr1_core_top.
// Delays harness-driven core inputs by DEPTH register stages, synchronises
// (or pipelines) the four reset requests, and can withhold memory acks and
// responses on selected channels for a programmed number of cycles.
// Ports:
//   clk, rst_n                 - clock, async active-low block reset
//   in_*_rst_n                 - raw reset requests      -> out_*_rst_n
//   in_test_mode/soft/timer    - raw controls            -> out_* (DEPTH later)
//   in_mtime_ext, in_fuse_*    - timer / hart id         -> out_* (DEPTH later)
//   in_mem_req_ack/rdata/resp  - per-channel memory side -> out_* (gated by stall)
//   stall_req/len/ch_mask      - stall programming
//   stall_busy                 - stall in progress
module scr1_in_stage
    import scr1_in_stage_pkg::*;
#(
    parameter int unsigned DEPTH           = 1,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned SYNC_RESETS     = 1,
    parameter int unsigned RST_SYNC_STAGES = 2,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     in_pwrup_rst_n,
    input  logic                     in_rst_n,
    input  logic                     in_cpu_rst_n,
    input  logic                     in_test_rst_n,
    input  logic                     in_test_mode,
    input  logic                     in_soft_irq,
    input  logic                     in_timer_irq,
    input  logic [63:0]              in_mtime_ext,
    input  logic [XLEN-1:0]          in_fuse_mhartid,
    input  logic [NUM_CH-1:0]        in_mem_req_ack,
    input  logic [NUM_CH*DATA_W-1:0] in_mem_rdata,
    input  logic [NUM_CH*2-1:0]      in_mem_resp,

    input  logic                     stall_req,
    input  logic [CNT_W-1:0]         stall_len,
    input  logic [NUM_CH-1:0]        stall_ch_mask,

    output logic                     out_pwrup_rst_n,
    output logic                     out_rst_n,
    output logic                     out_cpu_rst_n,
    output logic                     out_test_rst_n,
    output logic                     out_test_mode,
    output logic                     out_soft_irq,
    output logic                     out_timer_irq,
    output logic [63:0]              out_mtime_ext,
    output logic [XLEN-1:0]          out_fuse_mhartid,
    output logic [NUM_CH-1:0]        out_mem_req_ack,
    output logic [NUM_CH*DATA_W-1:0] out_mem_rdata,
    output logic [NUM_CH*2-1:0]      out_mem_resp,
    output logic                     stall_busy
);

    localparam int unsigned RDATA_W = NUM_CH * DATA_W;
    localparam int unsigned RESP_W  = NUM_CH * MEM_RESP_W;
    localparam int unsigned DATA_PW = 3 + 64 + XLEN + NUM_CH + RDATA_W + RESP_W;

    // ------------------------------------------------------------------
    // Data pipeline: every non-reset input, DEPTH stages, no bubbles
    // ------------------------------------------------------------------
    logic [DATA_PW-1:0] data_in;
    logic [DATA_PW-1:0] data_q [DEPTH];
    logic [DATA_PW-1:0] data_out;

    assign data_in = {in_test_mode, in_soft_irq, in_timer_irq, in_mtime_ext,
                      in_fuse_mhartid, in_mem_req_ack, in_mem_rdata, in_mem_resp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= data_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign data_out = data_q[DEPTH-1];

    logic [NUM_CH-1:0]  st_ack;
    logic [RDATA_W-1:0] st_rdata;
    logic [RESP_W-1:0]  st_resp;

    assign {out_test_mode, out_soft_irq, out_timer_irq, out_mtime_ext,
            out_fuse_mhartid, st_ack, st_rdata, st_resp} = data_out;

    // ------------------------------------------------------------------
    // Reset path: synchronisers, or plain DEPTH-stage data
    // ------------------------------------------------------------------
    generate
        if (SYNC_RESETS != 0) begin : g_rst_sync
            scr1_rst_sync_cell #(.STAGES(RST_SYNC_STAGES)) u_sync_pwrup (
                .clk       (clk),
                .rst_n     (rst_n),
                .rst_in_n  (in_pwrup_rst_n),
                .rst_out_n (out_pwrup_rst_n)
            );
            scr1_rst_sync_cell #(.STAGES(RST_SYNC_STAGES)) u_sync_rst (
                .clk       (clk),
                .rst_n     (rst_n),
                .rst_in_n  (in_rst_n),
                .rst_out_n (out_rst_n)
            );
            scr1_rst_sync_cell #(.STAGES(RST_SYNC_STAGES)) u_sync_cpu (
                .clk       (clk),
                .rst_n     (rst_n),
                .rst_in_n  (in_cpu_rst_n),
                .rst_out_n (out_cpu_rst_n)
            );
            scr1_rst_sync_cell #(.STAGES(RST_SYNC_STAGES)) u_sync_test (
                .clk       (clk),
                .rst_n     (rst_n),
                .rst_in_n  (in_test_rst_n),
                .rst_out_n (out_test_rst_n)
            );
        end else begin : g_rst_pipe
            logic [3:0] rst_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        rst_q[i] <= '0;
                    end
                end else begin
                    rst_q[0] <= {in_pwrup_rst_n, in_rst_n, in_cpu_rst_n, in_test_rst_n};
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        rst_q[i] <= rst_q[i-1];
                    end
                end
            end

            assign {out_pwrup_rst_n, out_rst_n, out_cpu_rst_n, out_test_rst_n} = rst_q[DEPTH-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stall FSM
    // ------------------------------------------------------------------
    type_scr1_stall_fsm_e state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [RDATA_W-1:0]   hold_q, hold_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            mask_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: a zero-length request is ignored; requests during STALL are ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        hold_d  = hold_q;
        case (state_q)
            RUN: begin
                if (stall_req && (stall_len != '0)) begin
                    state_d = STALL;
                    cnt_d   = stall_len;
                    mask_d  = stall_ch_mask;
                    // Freeze the rdata the core currently sees
                    hold_d  = st_rdata;
                end
            end
            STALL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: gate the last pipeline stage of masked channels while stalled
    always_comb begin
        stall_busy      = (state_q == STALL);
        out_mem_req_ack = st_ack;
        out_mem_rdata   = st_rdata;
        out_mem_resp    = st_resp;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if ((state_q == STALL) && mask_q[c]) begin
                out_mem_req_ack[c]                        = 1'b0;
                out_mem_resp[c*MEM_RESP_W +: MEM_RESP_W]  = SCR1_MEM_RESP_NOTRDY;
                out_mem_rdata[c*DATA_W +: DATA_W]         = hold_q[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule : scr1_in_stage

// File: tb/tb_scr1_in_stage.sv
// Scoreboard bench for scr1_in_stage: stimulus pushes cycle-tagged expected
// values, a negedge monitor pops and compares the ones due in that cycle.
module tb_scr1_in_stage;

    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hA111_1111;
    localparam logic [31:0] B0 = 32'hB000_0000;
    localparam logic [31:0] B1 = 32'hB111_1111;

    typedef enum int {
        S_BUSY, S_MTIME, S_MTIME2, S_CPU_RST, S_RST, S_RST2,
        S_ACK, S_RESP, S_RDATA0, S_RDATA1
    } sig_e;

    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [63:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic in_pwrup_rst_n, in_rst_n, in_cpu_rst_n, in_test_rst_n;
    logic in_test_mode, in_soft_irq, in_timer_irq;
    logic [63:0] in_mtime_ext;
    logic [31:0] in_fuse_mhartid;
    logic [1:0]  in_mem_req_ack;
    logic [63:0] in_mem_rdata;
    logic [3:0]  in_mem_resp;
    logic        stall_req;
    logic [7:0]  stall_len;
    logic [1:0]  stall_ch_mask;

    logic out_pwrup_rst_n, out_rst_n, out_cpu_rst_n, out_test_rst_n;
    logic out_test_mode, out_soft_irq, out_timer_irq;
    logic [63:0] out_mtime_ext;
    logic [31:0] out_fuse_mhartid;
    logic [1:0]  out_mem_req_ack;
    logic [63:0] out_mem_rdata;
    logic [3:0]  out_mem_resp;
    logic        stall_busy;

    logic out_pwrup_rst_n2, out_rst_n2, out_cpu_rst_n2, out_test_rst_n2;
    logic out_test_mode2, out_soft_irq2, out_timer_irq2;
    logic [63:0] out_mtime_ext2;
    logic [31:0] out_fuse_mhartid2;
    logic [1:0]  out_mem_req_ack2;
    logic [63:0] out_mem_rdata2;
    logic [3:0]  out_mem_resp2;
    logic        stall_busy2;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    scr1_in_stage #(
        .DEPTH(3), .NUM_CH(2), .DATA_W(32), .XLEN(32),
        .SYNC_RESETS(1), .RST_SYNC_STAGES(2), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_pwrup_rst_n(in_pwrup_rst_n), .in_rst_n(in_rst_n),
        .in_cpu_rst_n(in_cpu_rst_n), .in_test_rst_n(in_test_rst_n),
        .in_test_mode(in_test_mode), .in_soft_irq(in_soft_irq), .in_timer_irq(in_timer_irq),
        .in_mtime_ext(in_mtime_ext), .in_fuse_mhartid(in_fuse_mhartid),
        .in_mem_req_ack(in_mem_req_ack), .in_mem_rdata(in_mem_rdata), .in_mem_resp(in_mem_resp),
        .stall_req(stall_req), .stall_len(stall_len), .stall_ch_mask(stall_ch_mask),
        .out_pwrup_rst_n(out_pwrup_rst_n), .out_rst_n(out_rst_n),
        .out_cpu_rst_n(out_cpu_rst_n), .out_test_rst_n(out_test_rst_n),
        .out_test_mode(out_test_mode), .out_soft_irq(out_soft_irq), .out_timer_irq(out_timer_irq),
        .out_mtime_ext(out_mtime_ext), .out_fuse_mhartid(out_fuse_mhartid),
        .out_mem_req_ack(out_mem_req_ack), .out_mem_rdata(out_mem_rdata), .out_mem_resp(out_mem_resp),
        .stall_busy(stall_busy)
    );

    scr1_in_stage #(
        .DEPTH(2), .NUM_CH(2), .DATA_W(32), .XLEN(32),
        .SYNC_RESETS(0), .RST_SYNC_STAGES(2), .CNT_W(8)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_pwrup_rst_n(in_pwrup_rst_n), .in_rst_n(in_rst_n),
        .in_cpu_rst_n(in_cpu_rst_n), .in_test_rst_n(in_test_rst_n),
        .in_test_mode(in_test_mode), .in_soft_irq(in_soft_irq), .in_timer_irq(in_timer_irq),
        .in_mtime_ext(in_mtime_ext), .in_fuse_mhartid(in_fuse_mhartid),
        .in_mem_req_ack(in_mem_req_ack), .in_mem_rdata(in_mem_rdata), .in_mem_resp(in_mem_resp),
        .stall_req(stall_req), .stall_len(stall_len), .stall_ch_mask(stall_ch_mask),
        .out_pwrup_rst_n(out_pwrup_rst_n2), .out_rst_n(out_rst_n2),
        .out_cpu_rst_n(out_cpu_rst_n2), .out_test_rst_n(out_test_rst_n2),
        .out_test_mode(out_test_mode2), .out_soft_irq(out_soft_irq2), .out_timer_irq(out_timer_irq2),
        .out_mtime_ext(out_mtime_ext2), .out_fuse_mhartid(out_fuse_mhartid2),
        .out_mem_req_ack(out_mem_req_ack2), .out_mem_rdata(out_mem_rdata2), .out_mem_resp(out_mem_resp2),
        .stall_busy(stall_busy2)
    );

    function automatic string sig_name(input sig_e s);
        case (s)
            S_BUSY:    return "stall_busy";
            S_MTIME:   return "out_mtime_ext";
            S_MTIME2:  return "d2_out_mtime_ext";
            S_CPU_RST: return "out_cpu_rst_n";
            S_RST:     return "out_rst_n";
            S_RST2:    return "d2_out_rst_n";
            S_ACK:     return "out_mem_req_ack";
            S_RESP:    return "out_mem_resp";
            S_RDATA0:  return "imem_rdata";
            S_RDATA1:  return "dmem_rdata";
            default:   return "unknown";
        endcase
    endfunction

    function automatic logic [63:0] get_sig(input sig_e s);
        case (s)
            S_BUSY:    return 64'(stall_busy);
            S_MTIME:   return out_mtime_ext;
            S_MTIME2:  return out_mtime_ext2;
            S_CPU_RST: return 64'(out_cpu_rst_n);
            S_RST:     return 64'(out_rst_n);
            S_RST2:    return 64'(out_rst_n2);
            S_ACK:     return 64'(out_mem_req_ack);
            S_RESP:    return 64'(out_mem_resp);
            S_RDATA0:  return 64'(out_mem_rdata[31:0]);
            S_RDATA1:  return 64'(out_mem_rdata[63:32]);
            default:   return 64'hDEAD;
        endcase
    endfunction

    function automatic void expect_at(input int c, input sig_e s, input logic [63:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endfunction

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation that falls due in this cycle
    always @(negedge clk) begin
        logic [63:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                got = get_sig(sb[i].sig);
                n_tests++;
                if (got !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                             sig_name(sb[i].sig), cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        in_pwrup_rst_n  = 1'b1;
        in_rst_n        = 1'b1;
        in_cpu_rst_n    = 1'b1;
        in_test_rst_n   = 1'b1;
        in_test_mode    = 1'b0;
        in_soft_irq     = 1'b0;
        in_timer_irq    = 1'b0;
        in_mtime_ext    = 64'h55;
        in_fuse_mhartid = 32'h7;
        in_mem_req_ack  = 2'b11;
        in_mem_rdata    = {B0, A0};
        in_mem_resp     = 4'b0101;
        stall_req       = 1'b0;
        stall_len       = 8'd0;
        stall_ch_mask   = 2'b00;

        // Reset values while rst_n is low
        goto(2);
        n_tests++;
        if (out_mtime_ext !== 64'd0) begin
            n_fail++;
            $display("FAIL direct out_mtime_ext reset got=%0h", out_mtime_ext);
        end
        expect_at(2, S_BUSY, 64'd0);
        expect_at(2, S_MTIME, 64'd0);
        expect_at(2, S_ACK, 64'd0);
        expect_at(2, S_RESP, 64'd0);
        expect_at(2, S_CPU_RST, 64'd0);
        expect_at(2, S_RDATA1, 64'd0);
        expect_at(2, S_RST2, 64'd0);

        goto(3);
        rst_n = 1'b1;
        expect_at(4, S_CPU_RST, 64'd0);
        expect_at(5, S_CPU_RST, 64'd1);
        expect_at(4, S_RST2, 64'd0);
        expect_at(5, S_RST2, 64'd1);

        // Data latency: DEPTH=3 on dut, DEPTH=2 on dut2
        goto(10);
        in_mtime_ext = 64'h1234;
        expect_at(11, S_MTIME, 64'h55);
        expect_at(12, S_MTIME, 64'h55);
        expect_at(13, S_MTIME, 64'h1234);
        expect_at(11, S_MTIME2, 64'h55);
        expect_at(12, S_MTIME2, 64'h1234);
        goto(13);
        n_tests++;
        if (out_mtime_ext !== 64'h1234) begin
            n_fail++;
            $display("FAIL direct out_mtime_ext latency got=%0h", out_mtime_ext);
        end

        // Synchronised reset: async assert, release on 2nd edge
        goto(15);
        in_cpu_rst_n = 1'b0;
        expect_at(15, S_CPU_RST, 64'd0);
        #1;
        n_tests++;
        if (out_cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL direct out_cpu_rst_n async assert got=%0b", out_cpu_rst_n);
        end
        goto(19);
        in_cpu_rst_n = 1'b1;
        expect_at(20, S_CPU_RST, 64'd0);
        expect_at(21, S_CPU_RST, 64'd1);

        // in_rst_n: synchronised on dut, pipelined on dut2
        goto(24);
        in_rst_n = 1'b0;
        expect_at(24, S_RST, 64'd0);
        expect_at(24, S_RST2, 64'd1);
        expect_at(25, S_RST2, 64'd1);
        expect_at(26, S_RST2, 64'd0);
        goto(28);
        in_rst_n = 1'b1;
        expect_at(29, S_RST, 64'd0);
        expect_at(30, S_RST, 64'd1);
        expect_at(29, S_RST2, 64'd0);
        expect_at(30, S_RST2, 64'd1);

        // Stall dmem for 5 cycles
        goto(35);
        stall_req     = 1'b1;
        stall_len     = 8'd5;
        stall_ch_mask = 2'b10;
        expect_at(35, S_BUSY, 64'd0);
        expect_at(35, S_ACK, 64'd3);
        goto(36);
        stall_req    = 1'b0;
        in_mem_rdata = {B1, A1};
        for (int c = 36; c <= 40; c++) begin
            expect_at(c, S_BUSY, 64'd1);
            expect_at(c, S_ACK, 64'd1);
        end
        expect_at(36, S_RESP, 64'h1);
        expect_at(40, S_RESP, 64'h1);
        expect_at(41, S_BUSY, 64'd0);
        expect_at(41, S_ACK, 64'd3);
        expect_at(41, S_RESP, 64'h5);
        expect_at(38, S_RDATA1, 64'(B0));
        expect_at(40, S_RDATA1, 64'(B0));
        expect_at(41, S_RDATA1, 64'(B1));
        expect_at(38, S_RDATA0, 64'(A0));
        expect_at(39, S_RDATA0, 64'(A1));
        goto(38);
        n_tests++;
        if (out_mem_req_ack !== 2'b01) begin
            n_fail++;
            $display("FAIL direct out_mem_req_ack mid-stall got=%0b", out_mem_req_ack);
        end

        // Zero-length request is ignored
        goto(45);
        stall_req     = 1'b1;
        stall_len     = 8'd0;
        stall_ch_mask = 2'b11;
        goto(46);
        stall_req = 1'b0;
        expect_at(46, S_BUSY, 64'd0);
        expect_at(47, S_BUSY, 64'd0);
        expect_at(47, S_ACK, 64'd3);

        // Re-pulse mid-stall neither retriggers nor extends
        goto(50);
        stall_req     = 1'b1;
        stall_len     = 8'd4;
        stall_ch_mask = 2'b01;
        goto(51);
        stall_req = 1'b0;
        expect_at(51, S_BUSY, 64'd1);
        expect_at(51, S_ACK, 64'd2);
        goto(52);
        stall_req     = 1'b1;
        stall_len     = 8'd7;
        stall_ch_mask = 2'b10;
        goto(53);
        stall_req = 1'b0;
        expect_at(53, S_ACK, 64'd2);
        expect_at(54, S_BUSY, 64'd1);
        expect_at(55, S_BUSY, 64'd0);
        expect_at(55, S_ACK, 64'd3);

        // Block reset in the middle of a 10-cycle stall
        goto(60);
        stall_req     = 1'b1;
        stall_len     = 8'd10;
        stall_ch_mask = 2'b11;
        goto(61);
        stall_req = 1'b0;
        expect_at(61, S_BUSY, 64'd1);
        expect_at(62, S_ACK, 64'd0);
        goto(63);
        rst_n = 1'b0;
        expect_at(63, S_BUSY, 64'd0);
        expect_at(63, S_ACK, 64'd0);
        expect_at(63, S_RESP, 64'd0);
        expect_at(63, S_MTIME, 64'd0);
        expect_at(63, S_CPU_RST, 64'd0);
        expect_at(63, S_RDATA1, 64'd0);
        #1;
        n_tests++;
        if (stall_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL direct stall_busy after rst_n got=%0b", stall_busy);
        end
        goto(65);
        rst_n = 1'b1;
        expect_at(66, S_BUSY, 64'd0);
        expect_at(68, S_ACK, 64'd3);
        expect_at(68, S_RESP, 64'h5);
        expect_at(68, S_RDATA1, 64'(B1));
        expect_at(69, S_BUSY, 64'd0);

        goto(75);
        // Any expectation still queued was never reached
        while (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s cyc=%0d got=unchecked exp=%0h",
                     sig_name(sb[0].sig), sb[0].cyc, sb[0].val);
            void'(sb.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scr1_in_stage

// File: doc/scr1_in_stage.md
Name: scr1_in_stage

Overview:
- Parametrised input-staging block between the fuzz harness and scr1_core_top.
- Delays every harness-driven core input by a configurable number of register stages.
- Synchronises the four reset inputs: assertion is asynchronous, deassertion is synchronous.
- Carries NUM_CH memory response channels and a stall injector that withholds acks/responses for a programmed count, so the core sees back-pressure.

Parameters:
- DEPTH, 1, register stages on data/IRQ/memory paths (legal 1..4).
- NUM_CH, 2, memory response channels (ch0 = imem, ch1 = dmem; legal 1..4).
- DATA_W, 32, rdata width per channel.
- XLEN, 32, fuse_mhartid width.
- SYNC_RESETS, 1, 1: reset inputs go through synchronisers; 0: reset inputs use the DEPTH pipeline.
- RST_SYNC_STAGES, 2, synchroniser flop count (legal 2..3).
- CNT_W, 8, stall length counter width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  block reset, asynchronous, active-low
- in_pwrup_rst_n, in_rst_n, in_cpu_rst_n, in_test_rst_n  in  1 each  raw reset requests
- in_test_mode, in_soft_irq, in_timer_irq  in  1 each  raw controls
- in_mtime_ext  in  64  external timer
- in_fuse_mhartid  in  XLEN  hart id
- in_mem_req_ack  in  NUM_CH  per-channel ack
- in_mem_rdata  in  NUM_CH*DATA_W  packed rdata, ch0 in LSBs
- in_mem_resp  in  NUM_CH*2  packed type_scr1_mem_resp_e
- stall_req  in  1  start stall
- stall_len  in  CNT_W  stall cycles
- stall_ch_mask  in  NUM_CH  channels to stall
- out_*  out  same widths  staged versions of every in_* above
- stall_busy  out  1  stall active

Behaviour:
- Reset values (rst_n low, asynchronous):
  - All pipeline flops 0.
  - out_* reset outputs 0 (asserted).
  - out_mem_resp = SCR1_MEM_RESP_NOTRDY (2'b00).
  - out_mem_req_ack 0; stall_busy 0; FSM = RUN; counter 0.
- Data path:
  - Every non-reset input passes through DEPTH flops; latency exactly DEPTH cycles.
  - No bubbles; the pipeline never stalls.
- Reset path, SYNC_RESETS=1:
  - Each reset input feeds one synchroniser.
  - Input low OR rst_n low clears the chain asynchronously, so the output goes 0 in the same cycle.
  - On input high, the output goes 1 on the RST_SYNC_STAGES-th rising edge.
  - Reset path latency is independent of DEPTH.
- Reset path, SYNC_RESETS=0: reset inputs are plain DEPTH-stage data.
- Stall FSM, states RUN and STALL:
  - RUN -> STALL: sampled stall_req=1 and stall_len!=0. Load cnt=stall_len; latch mask=stall_ch_mask; stall_busy=1 from that edge.
  - RUN with stall_len=0: request ignored.
  - STALL: cnt decrements every edge. When cnt==1, the next edge returns to RUN and clears stall_busy. stall_busy is therefore high exactly stall_len cycles.
  - STALL: stall_req ignored (no retrigger, no extension); a latched mask of 0 still consumes the cycles.
- Masking:
  - For each channel c, while stall_busy and mask[c]: out_mem_req_ack[c]=0 and out_mem_resp[c]=NOTRDY.
  - out_mem_rdata[c] holds the value present at stall entry.
  - Gating is on the last stage output (combinational off registered state).
  - Pipeline contents leaving during the stall are dropped, not replayed.
  - Unmasked channels, IRQ, mtime, fuse and reset outputs are unaffected.
- rst_n low during STALL: immediate RUN, cnt 0, all outputs to reset values.
- Simultaneous stall_req and reset deassertion edge: request sampled normally.

Decomposition:
- Package scr1_in_stage_pkg holds:
  - Legal-range constants: DEPTH_MAX=4, NUM_CH_MAX=4.
  - Channel index constants: SCR1_CH_IMEM=0, SCR1_CH_DMEM=1.
  - Stall state enum type_scr1_stall_fsm_e {RUN, STALL}.
- type_scr1_mem_resp_e stays in scr1_memif.svh.
- Sub-module scr1_rst_sync_cell: one synchroniser with parameter STAGES, async clear, instantiated four times.

Test Plan:
- DEPTH=3: in_mtime_ext=64'h1234 at cycle 10 -> out_mtime_ext=64'h1234 at cycle 13, prior value through cycle 12.
- Reset sync, RST_SYNC_STAGES=2:
  - in_cpu_rst_n low -> out_cpu_rst_n low same cycle.
  - Raise at edge 20 -> out high after edge 21, not before.
- Stall, mask=2'b10, len=5: in_mem_req_ack=2'b11, resp READY ->
  - stall_busy high exactly 5 cycles.
  - out_mem_req_ack=2'b01 and dmem resp NOTRDY during those 5 cycles.
  - dmem rdata frozen.
  - Imem unaffected.
- stall_len=0, and stall_req re-pulsed mid-stall -> no effect; busy duration unchanged.
- rst_n low at cycle 3 of a 10-cycle stall -> stall_busy 0 and all outputs at reset values immediately; after release, RUN with no residual stall.
- SYNC_RESETS=0, DEPTH=2: in_rst_n edge -> out_rst_n follows 2 cycles later.
